// File: rtl/regfile_operand_fetch.sv
// Operand-fetch stage between decode and execute: drives the regfile read/write ports,
// tracks outstanding destination writes in a busy scoreboard and registers the operands.
module regfile_operand_fetch #(
    parameter int unsigned W = 8,
    parameter int unsigned N = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_src1,
    input  logic         in_use1,
    input  logic [N-1:0] in_src2,
    input  logic         in_use2,
    input  logic [N-1:0] in_dst,
    input  logic         in_dst_en,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_op1,
    output logic [W-1:0] out_op2,
    output logic [N-1:0] out_dst,
    output logic         out_dst_en,
    input  logic         wb_en,
    input  logic [N-1:0] wb_reg,
    input  logic [W-1:0] wb_data,
    output logic [N-1:0] rreg1,
    output logic [N-1:0] rreg2,
    input  logic [W-1:0] rdata1,
    input  logic [W-1:0] rdata2,
    output logic         write,
    output logic [N-1:0] wreg,
    output logic [W-1:0] wdata
);

    localparam int unsigned NREG = 2 ** N;

    logic [NREG-1:0] r_busy;
    logic            r_out_valid;
    logic [W-1:0]    r_op1;
    logic [W-1:0]    r_op2;
    logic [N-1:0]    r_dst;
    logic            r_dst_en;

    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_blk;
    logic [NREG-1:0] w_set;
    logic            w_hazard;
    logic            w_ready;
    logic            w_accept;
    logic [W-1:0]    w_op1;
    logic [W-1:0]    w_op2;

    assign rreg1 = in_src1;
    assign rreg2 = in_src2;
    assign write = wb_en & ~reset;
    assign wreg  = wb_reg;
    assign wdata = wb_data;

    // A writeback landing this cycle releases its register immediately.
    always_comb begin
        w_clr = '0;
        if (wb_en) begin
            w_clr[wb_reg] = 1'b1;
        end
    end

    assign w_blk    = r_busy & ~w_clr;
    assign w_hazard = (in_use1 & w_blk[in_src1]) | (in_use2 & w_blk[in_src2])
                    | (in_dst_en & w_blk[in_dst]);
    assign w_ready  = ~reset & ~w_hazard & (~r_out_valid | out_ready);
    assign w_accept = in_valid & w_ready;
    assign in_ready = w_ready;

    always_comb begin
        w_set = '0;
        if (w_accept && in_dst_en) begin
            w_set[in_dst] = 1'b1;
        end
    end

    // Regfile still returns the pre-write value this cycle, so bypass from writeback.
    assign w_op1 = !in_use1 ? '0 : (w_clr[in_src1] ? wb_data : rdata1);
    assign w_op2 = !in_use2 ? '0 : (w_clr[in_src2] ? wb_data : rdata2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_busy      <= '0;
            r_out_valid <= 1'b0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_dst       <= '0;
            r_dst_en    <= 1'b0;
        end else begin
            // Set wins over a same-cycle clear of the same register.
            r_busy <= (r_busy & ~w_clr) | w_set;
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_op1       <= w_op1;
                r_op2       <= w_op2;
                r_dst       <= in_dst;
                r_dst_en    <= in_dst_en;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_op1    = r_op1;
    assign out_op2    = r_op2;
    assign out_dst    = r_dst;
    assign out_dst_en = r_dst_en;

endmodule

// File: tb/tb_regfile_operand_fetch.sv
// Bench for regfile_operand_fetch: directed vector table plus random traffic, both checked
// against a reference model of the regfile and busy scoreboard with an operand queue.
module tb_regfile_operand_fetch;

    localparam int unsigned W = 8;
    localparam int unsigned N = 5;
    localparam int unsigned NREG = 32;

    typedef struct {
        bit       rst, v, u1;
        bit [4:0] s1;
        bit       u2;
        bit [4:0] s2;
        bit       de;
        bit [4:0] d;
        bit       ordy, wb;
        bit [4:0] wr;
        bit [7:0] wd;
        bit       chk, exp_rdy, chk_o, exp_ov;
        bit [7:0] exp_o1;
    } vec_t;

    typedef struct {
        bit [7:0] op1, op2;
        bit [4:0] dst;
        bit       dst_en;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0, in_use1 = 1'b0, in_use2 = 1'b0, in_dst_en = 1'b0;
    logic [N-1:0] in_src1 = '0, in_src2 = '0, in_dst = '0, wb_reg = '0;
    logic out_ready = 1'b0, wb_en = 1'b0;
    logic [W-1:0] wb_data = '0;
    logic in_ready, out_valid, out_dst_en, write;
    logic [W-1:0] out_op1, out_op2, rdata1, rdata2, wdata;
    logic [N-1:0] out_dst, rreg1, rreg2, wreg;

    logic [W-1:0] rf [NREG];
    logic rf_clr = 1'b1;

    int n_vec = 0;
    int n_err = 0;

    bit [7:0] m_rf [NREG];
    bit [NREG-1:0] m_busy;
    bit m_ov;
    bit seen_rst;
    exp_t q[$];
    int n_acc;

    always #5 clk = ~clk;

    // Environment regfile: combinational read, posedge write.
    assign rdata1 = rf[rreg1];
    assign rdata2 = rf[rreg2];
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < int'(NREG); i++) rf[i] <= '0;
        end else if (write) begin
            rf[wreg] <= wdata;
        end
    end

    regfile_operand_fetch #(.W(W), .N(N)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_src1(in_src1), .in_use1(in_use1), .in_src2(in_src2), .in_use2(in_use2),
        .in_dst(in_dst), .in_dst_en(in_dst_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_dst(out_dst), .out_dst_en(out_dst_en),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
        .rreg1(rreg1), .rreg2(rreg2), .rdata1(rdata1), .rdata2(rdata2),
        .write(write), .wreg(wreg), .wdata(wdata)
    );

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rst, bit v, bit u1, bit [4:0] s1, bit u2, bit [4:0] s2,
                                bit de, bit [4:0] d, bit ordy, bit wb, bit [4:0] wr,
                                bit [7:0] wd, bit exp_rdy, bit chk_o, bit exp_ov,
                                bit [7:0] exp_o1);
        vec_t x;
        x.rst = rst; x.v = v; x.u1 = u1; x.s1 = s1; x.u2 = u2; x.s2 = s2;
        x.de = de; x.d = d; x.ordy = ordy; x.wb = wb; x.wr = wr; x.wd = wd;
        x.chk = 1'b1; x.exp_rdy = exp_rdy; x.chk_o = chk_o; x.exp_ov = exp_ov;
        x.exp_o1 = exp_o1;
        return x;
    endfunction

    // One clock cycle: drive, sample mid-cycle, compare, then advance the model.
    task automatic step(input vec_t x);
        bit hz, rdy, acc, clr1, clr2;
        exp_t e;
        @(posedge clk);
        #1;
        reset = x.rst; in_valid = x.v;
        in_use1 = x.u1; in_src1 = x.s1; in_use2 = x.u2; in_src2 = x.s2;
        in_dst_en = x.de; in_dst = x.d; out_ready = x.ordy;
        wb_en = x.wb; wb_reg = x.wr; wb_data = x.wd;
        #3;
        hz = (x.u1 && m_busy[x.s1] && !(x.wb && x.wr == x.s1))
           || (x.u2 && m_busy[x.s2] && !(x.wb && x.wr == x.s2))
           || (x.de && m_busy[x.d] && !(x.wb && x.wr == x.d));
        rdy = !x.rst && !hz && (!m_ov || x.ordy);
        acc = x.v && rdy;
        if (seen_rst || x.rst) chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("rreg1", 32'(rreg1), 32'(x.s1));
        chk("rreg2", 32'(rreg2), 32'(x.s2));
        chk("write", 32'(write), 32'(x.wb && !x.rst));
        if (x.wb && !x.rst) begin
            chk("wreg", 32'(wreg), 32'(x.wr));
            chk("wdata", 32'(wdata), 32'(x.wd));
        end
        if (seen_rst) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                if (q.size() == 0) begin
                    chk("queue_nonempty", 32'(0), 32'(1));
                end else begin
                    chk("out_op1", 32'(out_op1), 32'(q[0].op1));
                    chk("out_op2", 32'(out_op2), 32'(q[0].op2));
                    chk("out_dst", 32'(out_dst), 32'(q[0].dst));
                    chk("out_dst_en", 32'(out_dst_en), 32'(q[0].dst_en));
                end
            end
        end
        if (x.chk) begin
            chk("tbl_in_ready", 32'(in_ready), 32'(x.exp_rdy));
            if (x.chk_o) begin
                chk("tbl_out_valid", 32'(out_valid), 32'(x.exp_ov));
                if (x.exp_ov) chk("tbl_out_op1", 32'(out_op1), 32'(x.exp_o1));
            end
        end
        // Reference model update for the coming posedge.
        if (x.rst) begin
            m_ov = 1'b0;
            m_busy = '0;
            q.delete();
            seen_rst = 1'b1;
        end else begin
            clr1 = x.wb && x.wr == x.s1;
            clr2 = x.wb && x.wr == x.s2;
            if (m_ov && x.ordy && q.size() > 0) void'(q.pop_front());
            if (x.wb) m_busy[x.wr] = 1'b0;
            if (acc) begin
                e.op1 = !x.u1 ? 8'h00 : (clr1 ? x.wd : m_rf[x.s1]);
                e.op2 = !x.u2 ? 8'h00 : (clr2 ? x.wd : m_rf[x.s2]);
                e.dst = x.d;
                e.dst_en = x.de;
                q.push_back(e);
                m_ov = 1'b1;
                n_acc++;
                if (x.de) m_busy[x.d] = 1'b1;
            end else if (x.ordy) begin
                m_ov = 1'b0;
            end
            if (x.wb) m_rf[x.wr] = x.wd;
        end
    endtask

    initial begin
        vec_t tbl[$];
        vec_t r;
        int cyc;
        int bl[$];
        for (int i = 0; i < int'(NREG); i++) m_rf[i] = 8'h00;
        m_busy = '0; m_ov = 1'b0; seen_rst = 1'b0; n_acc = 0;

        //            rst v u1 s1 u2 s2 de d ordy wb wr wd      rdy chko ov o1
        tbl.push_back(mk(1, 1, 1, 3, 1, 17, 0, 0, 1, 1, 5, 8'hFF, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 1, 1, 3, 1, 17, 0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 1, 3, 1, 17, 0, 0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 5, 8'hA7, 1, 1, 1, 8'h00));
        tbl.push_back(mk(0, 1, 1, 5, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 9, 1, 0, 0, 8'h00, 1, 1, 1, 8'hA7));
        tbl.push_back(mk(0, 1, 1, 9, 0, 0,  0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 8'h00));
        tbl.push_back(mk(0, 1, 1, 9, 0, 0,  0, 0, 1, 0, 0, 8'h00, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 1, 9, 0, 0,  0, 0, 1, 1, 9, 8'h3C, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 1, 8'h3C));
        tbl.push_back(mk(0, 1, 1, 9, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h00));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 1, 1, 8'h3C));
        tbl.push_back(mk(0, 1, 1, 3, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 1, 8'h3C));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 1, 8'h00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 4, 1, 0, 0, 8'h00, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 4, 1, 0, 0, 8'h00, 0, 1, 1, 8'h00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 4, 1, 1, 4, 8'h55, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 1, 4, 0, 0,  0, 0, 1, 0, 0, 8'h00, 0, 1, 1, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 4, 8'h66, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0,  1, 7, 0, 0, 0, 8'h00, 1, 1, 0, 8'h00));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 1, 2, 8'hEE, 0, 1, 1, 8'h00));
        tbl.push_back(mk(0, 1, 1, 7, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 1, 1, 2, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 1, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 1, 8'h00));
        tbl.push_back(mk(0, 1, 1, 12, 1, 12, 0, 0, 1, 1, 12, 8'h5A, 1, 1, 0, 8'h00));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 1, 0, 0, 8'h00, 1, 1, 1, 8'h5A));

        @(posedge clk);
        #1 rf_clr = 1'b0;
        foreach (tbl[i]) step(tbl[i]);

        // Random traffic over a small register window to provoke hazards.
        n_acc = 0;
        cyc = 0;
        while (n_acc < 1000 && cyc < 20000) begin
            r = tbl[0];
            r.chk = 1'b0;
            r.rst = ($urandom_range(0, 99) == 0);
            r.v   = ($urandom_range(0, 3) != 0);
            r.u1  = $urandom_range(0, 1) != 0; r.s1 = 5'($urandom_range(0, 7));
            r.u2  = $urandom_range(0, 1) != 0; r.s2 = 5'($urandom_range(0, 7));
            r.de  = $urandom_range(0, 1) != 0;
            r.d   = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(0, 31))
                                                : 5'($urandom_range(0, 7));
            r.ordy = ($urandom_range(0, 3) != 0);
            r.wb  = ($urandom_range(0, 9) < 4);
            r.wd  = 8'($urandom_range(0, 255));
            bl.delete();
            for (int i = 0; i < int'(NREG); i++) if (m_busy[i]) bl.push_back(i);
            if (bl.size() > 0 && $urandom_range(0, 3) != 0)
                r.wr = 5'(bl[$urandom_range(0, bl.size() - 1)]);
            else
                r.wr = 5'($urandom_range(0, 31));
            step(r);
            cyc++;
        end
        chk("random_accepts", 32'(n_acc >= 1000), 32'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
